la_syncarb: RTL and testbench

LA_SYNCARB -- requirements
Module: la_syncarb

---
 rtl/la_syncarb.sv | 137 +++++++++++++
 tb/tb_la_syncarb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/la_syncarb.sv
// Round-robin arbiter granting a local resource to N asynchronous 4-phase requesters.
// Each request line is synchronized before use; grant/ack are registered and mutually exclusive.

module la_syncarb_dsync #(
    parameter     PROP   = "DEFAULT",
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_pipe;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_pipe[STAGES-1];

endmodule

module la_syncarb #(
    parameter     PROP   = "DEFAULT",
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] req_async,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic [N-1:0] ack,
    output logic         busy
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    logic [N-1:0]  w_sreq;
    logic          w_any;
    logic [KW-1:0] w_sel;
    int unsigned   w_idx;
    logic [KW-1:0] w_next_ptr;

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [KW-1:0] r_ptr;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_ack;
    logic          r_busy;

    for (genvar g = 0; g < N; g++) begin : g_sync
        la_syncarb_dsync #(
            .PROP   (PROP),
            .STAGES (STAGES)
        ) u_sync (
            .clk    (clk),
            .nreset (nreset),
            .i_d    (req_async[g]),
            .o_q    (w_sreq[g])
        );
    end

    // Scan from the farthest offset down so the nearest set index after ptr wins.
    always_comb begin
        w_any = |w_sreq;
        w_sel = '0;
        w_idx = 0;
        for (int unsigned i = N; i > 0; i--) begin
            w_idx = (int'(r_ptr) + i - 1) % N;
            if (w_sreq[w_idx]) begin
                w_sel = KW'(w_idx);
            end
        end
    end

    assign w_next_ptr = (r_k == KW'(N - 1)) ? '0 : r_k + 1'b1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_k     <= w_sel;
                        r_grant <= N'(1) << w_sel;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (done) begin
                        r_grant <= '0;
                        r_ack   <= N'(1) << r_k;
                        r_ptr   <= w_next_ptr;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (!w_sreq[r_k]) begin
                        r_ack   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign ack   = r_ack;
    assign busy  = r_busy;

endmodule

// File: tb/tb_la_syncarb.sv
// Randomized and directed bench for la_syncarb, checked against a transaction-level
// model (delay-line queue for the synchronizers, index-based arbitration).

module tb_la_syncarb;

    localparam int N      = 4;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         nreset;
    logic [N-1:0] req_async;
    logic         done;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic         busy;

    always #5 clk = ~clk;

    la_syncarb #(
        .PROP   ("DEFAULT"),
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_async (req_async),
        .done      (done),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who holds the grant, who is being acked, where the scan starts.
    int           m_gnt;
    int           m_ack;
    int           m_ptr;
    logic [N-1:0] m_hist[$];
    logic [N-1:0] prev_grant;
    int           q_gr[$];

    function automatic void model_reset();
        m_gnt = -1;
        m_ack = -1;
        m_ptr = 0;
        m_hist.delete();
        for (int i = 0; i < STAGES; i++) m_hist.push_back('0);
    endfunction

    function automatic void model_edge(input logic [N-1:0] r, input logic d);
        logic [N-1:0] s;
        s = m_hist[STAGES-1];
        if (m_gnt >= 0) begin
            if (d) begin
                m_ack = m_gnt;
                m_ptr = (m_gnt + 1) % N;
                m_gnt = -1;
            end
        end else if (m_ack >= 0) begin
            if (!s[m_ack]) m_ack = -1;
        end else begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (s[j]) begin
                    m_gnt = j;
                    break;
                end
            end
        end
        m_hist.push_front(r);
        void'(m_hist.pop_back());
    endfunction

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!nreset) model_reset();
        else model_edge(req_async, done);
        #1;
        chk("grant", grant, bit_of(m_gnt));
        chk("ack", ack, bit_of(m_ack));
        chk("busy", busy, (m_gnt >= 0 || m_ack >= 0));
        chk("excl", (|grant) && (|ack), 0);
        chk("onehot", $onehot0(grant) && $onehot0(ack), 1);
        if (grant != '0 && prev_grant == '0) q_gr.push_back(int'(grant));
        prev_grant = grant;
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        req_async = r;
        done      = d;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset    = 1'b0;
        req_async = '0;
        done      = 1'b0;
        step();
        step();
        @(negedge clk);
        nreset = 1'b1;
        step();
    endtask

    // Requesters follow 4-phase: drop on ack, re-raise once ack is gone.
    task automatic agent_cyc(input logic [N-1:0] mask, input int done_pct,
                             input int raise_pct, input int flip_pct);
        logic [N-1:0] r;
        logic         d;
        @(negedge clk);
        r = req_async;
        for (int i = 0; i < N; i++) begin
            if (!mask[i]) begin
                r[i] = 1'b0;
            end else begin
                if (r[i] && ack[i]) r[i] = 1'b0;
                else if (!r[i] && !ack[i] && ($urandom_range(99) < raise_pct)) r[i] = 1'b1;
                if ($urandom_range(99) < flip_pct) r[i] = ~r[i];
            end
        end
        d = (grant != '0) && ($urandom_range(99) < done_pct);
        req_async = r;
        done      = d;
        step();
    endtask

    initial begin
        int cnt;
        int exp_rr[5];
        int exp_fair[4];
        bit seen;

        exp_rr   = '{1, 2, 4, 8, 1};
        exp_fair = '{1, 8, 1, 8};
        prev_grant = '0;
        model_reset();

        // Reset held with every input active
        nreset    = 1'b0;
        req_async = '1;
        done      = 1'b1;
        #2;
        chk("rst_async_grant", grant, 0);
        for (int i = 0; i < 4; i++) cyc('1, 1'b1);
        @(negedge clk);
        nreset = 1'b1;
        seen = 0;
        for (int i = 0; i < STAGES + 1 && !seen; i++) begin
            step();
            if (busy) seen = 1;
        end
        chk("busy_rise", seen, 1);

        // Single request, exact latencies, stray done in IDLE and ACK
        do_reset();
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        chk("idle_done_busy", busy, 0);
        cyc(4'b0100, 1'b0);
        chk("e0_grant", grant, 0);
        cyc(4'b0100, 1'b0);
        chk("e1_grant", grant, 0);
        cyc(4'b0100, 1'b0);
        chk("e2_grant", grant, 4'b0100);
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        chk("e4_grant", grant, 4'b0100);
        cyc(4'b0100, 1'b1);
        chk("e5_grant", grant, 0);
        chk("e5_ack", ack, 4'b0100);
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        chk("e7_ack", ack, 4'b0100);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        chk("e9_ack", ack, 4'b0100);
        cyc(4'b0000, 1'b0);
        chk("e10_ack", ack, 0);
        chk("e10_busy", busy, 0);

        // Round robin with all four requesters
        do_reset();
        q_gr.delete();
        cnt = 0;
        while (q_gr.size() < 5 && cnt < 200) begin
            agent_cyc(4'b1111, 100, 100, 0);
            cnt++;
        end
        chk("rr_count", q_gr.size() >= 5, 1);
        for (int i = 0; i < 5 && i < q_gr.size(); i++) chk("rr_order", q_gr[i], exp_rr[i]);

        // Fairness between requesters 0 and 3
        do_reset();
        q_gr.delete();
        cnt = 0;
        while (q_gr.size() < 4 && cnt < 200) begin
            agent_cyc(4'b1001, 100, 100, 0);
            cnt++;
        end
        chk("fair_count", q_gr.size() >= 4, 1);
        for (int i = 0; i < 4 && i < q_gr.size(); i++) chk("fair_order", q_gr[i], exp_fair[i]);

        // Asynchronous reset while requester 1 holds the grant
        do_reset();
        cnt = 0;
        while (grant != 4'b0010 && cnt < 10) begin
            cyc(4'b0010, 1'b0);
            cnt++;
        end
        chk("mid_grant_seen", grant, 4'b0010);
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        @(negedge clk);
        nreset = 1'b1;
        step();
        cnt = 0;
        while (grant != 4'b0010 && cnt < STAGES + 1) begin
            cyc(4'b0010, 1'b0);
            cnt++;
        end
        chk("regrant", grant, 4'b0010);

        // Randomized traffic with occasional protocol glitches
        do_reset();
        for (int i = 0; i < 600; i++) agent_cyc(4'b1111, 35, 50, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
